// File: rtl/seq_mult_sixteen.sv
// Sequential unsigned shift-and-add multiplier: 16 iterations plus one completion cycle,
// with a start/busy/done handshake and active-low write strobes for the product-half registers.
module seq_mult_sixteen #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               START,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] P,
  output logic               OVF,
  output logic               RW_LO,
  output logic               RW_HI
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned AW = PW + 1;
  localparam int unsigned SW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_acc;
  logic [AW-1:0]    w_acc_nxt;
  logic [AW-1:0]    w_acc_add;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] w_mcand_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [SW-1:0]    w_sum;
  logic [PW-1:0]    w_p_nxt;
  logic             w_ovf_nxt;

  // Next-state and datapath: conditional add into the upper half, then shift right by one.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_mcand_nxt = r_mcand;
    w_cnt_nxt   = r_cnt;
    w_p_nxt     = P;
    w_ovf_nxt   = OVF;
    w_sum       = SW'(r_acc[PW-1:WIDTH]) + SW'(r_mcand);
    w_acc_add   = r_acc[0] ? {w_sum, r_acc[WIDTH-1:0]} : r_acc;

    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_mcand_nxt = A;
          w_acc_nxt   = AW'(B);
          w_cnt_nxt   = '0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_acc_nxt = {1'b0, w_acc_add[AW-1:1]};
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_state_nxt = S_FIN;
          w_p_nxt     = w_acc_nxt[PW-1:0];
          w_ovf_nxt   = |w_acc_nxt[PW-1:WIDTH];
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; handshake outputs follow the next state.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      P       <= '0;
      OVF     <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RW_LO   <= 1'b1;
      RW_HI   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_mcand <= w_mcand_nxt;
      r_cnt   <= w_cnt_nxt;
      P       <= w_p_nxt;
      OVF     <= w_ovf_nxt;
      BUSY    <= (w_state_nxt == S_RUN);
      DONE    <= (w_state_nxt == S_FIN);
      RW_LO   <= (w_state_nxt != S_FIN);
      RW_HI   <= (w_state_nxt != S_FIN);
    end
  end

endmodule

// File: tb/tb_seq_mult_sixteen.sv
// Bench for seq_mult_sixteen: cycle model built on plain multiplication plus directed
// vectors with hand-computed products.
module tb_seq_mult_sixteen;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        START;
  logic [15:0] A;
  logic [15:0] B;
  logic        BUSY;
  logic        DONE;
  logic [31:0] P;
  logic        OVF;
  logic        RW_LO;
  logic        RW_HI;

  int nvec     = 0;
  int nerr     = 0;
  int cyc      = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

  // Model: phase -1 idle, 0..15 busy, 16 completion cycle.
  int          m_ph   = -1;
  logic [31:0] m_prod = '0;
  logic [31:0] m_p    = '0;
  logic        m_ovf  = 1'b0;

  seq_mult_sixteen #(.WIDTH(16)) dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .START (START),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .P     (P),
    .OVF   (OVF),
    .RW_LO (RW_LO),
    .RW_HI (RW_HI)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  always @(posedge CLK) begin
    cyc++;
    if (CLR) begin
      m_ph  = -1;
      m_p   = '0;
      m_ovf = 1'b0;
    end else if (m_ph < 0) begin
      if (START) begin
        m_prod = 32'(A) * 32'(B);
        m_ph   = 0;
      end
    end else if (m_ph < 15) begin
      m_ph++;
    end else if (m_ph == 15) begin
      m_ph  = 16;
      m_p   = m_prod;
      m_ovf = (m_prod > 32'h0000_FFFF);
    end else begin
      m_ph = -1;
    end
  end

  // Every-cycle comparison against the model, sampled away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("p", P, m_p);
      chk("ovf", 32'(OVF), 32'(m_ovf));
      chk("busy", 32'(BUSY), 32'(m_ph >= 0 && m_ph < 16));
      chk("done", 32'(DONE), 32'(m_ph == 16));
      chk("rw_lo", 32'(RW_LO), 32'(m_ph != 16));
      chk("rw_hi", 32'(RW_HI), 32'(m_ph != 16));
      chk("busy_done_excl", 32'(BUSY & DONE), 32'd0);
      if (DONE) done_cnt++;
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_p, input logic exp_ovf, input string nm);
    int nb;
    bit got;
    nb  = 0;
    got = 1'b0;
    A = a; B = b; START = 1'b1;
    tick(1);
    START = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (BUSY) nb++;
      if (DONE) begin
        got = 1'b1;
        break;
      end
      tick(1);
    end
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    chk({nm, "_busy_cycles"}, 32'(nb), 32'd16);
    chk({nm, "_p"}, P, exp_p);
    chk({nm, "_model_p"}, m_p, exp_p);
    chk({nm, "_ovf"}, 32'(OVF), 32'(exp_ovf));
    chk({nm, "_rw_lo_low"}, 32'(RW_LO), 32'd0);
    chk({nm, "_rw_hi_low"}, 32'(RW_HI), 32'd0);
    tick(1);
    chk({nm, "_done_drop"}, 32'(DONE), 32'd0);
    chk({nm, "_rw_lo_high"}, 32'(RW_LO), 32'd1);
    chk({nm, "_rw_hi_high"}, 32'(RW_HI), 32'd1);
    chk({nm, "_p_hold"}, P, exp_p);
  endtask

  initial begin
    int d0;
    int last_done;
    int ndone;
    bit got;

    // Reset with START asserted: nothing may be accepted.
    CLR = 1'b1; START = 1'b1; A = 16'h0003; B = 16'h0005;
    tick(1);
    chk_en = 1'b1;
    tick(1);
    chk("rst_p", P, 32'h0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_ovf", 32'(OVF), 32'd0);
    chk("rst_rw", {30'd0, RW_HI, RW_LO}, 32'd3);
    CLR = 1'b0; START = 1'b0;
    tick(2);
    chk("idle_after_rst", 32'(BUSY), 32'd0);

    run_op(16'h0003, 16'h0005, 32'h0000_000F, 1'b0, "small");
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1, "max");
    run_op(16'h1234, 16'h0000, 32'h0000_0000, 1'b0, "zero");

    // Operand changes and START pulses after acceptance must be ignored.
    d0 = done_cnt;
    A = 16'h00FF; B = 16'h0101; START = 1'b1;
    tick(1);
    START = 1'b0;
    tick(3);
    A = 16'hAAAA; B = 16'h5555; START = 1'b1;
    tick(1);
    START = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (DONE) begin
        got = 1'b1;
        break;
      end
      tick(1);
    end
    chk("ign_done_seen", 32'(got), 32'd1);
    chk("ign_p", P, 32'h0000_FFFF);
    START = 1'b1;
    tick(1);
    START = 1'b0;
    tick(20);
    chk("ign_one_done", 32'(done_cnt - d0), 32'd1);
    chk("ign_no_extra", 32'(BUSY), 32'd0);

    // Continuous START: completions every 18 cycles.
    A = 16'h0100; B = 16'h0100; START = 1'b1;
    last_done = -1;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (DONE) begin
        chk("cont_p", P, 32'h0001_0000);
        chk("cont_ovf", 32'(OVF), 32'd1);
        if (last_done >= 0) chk("cont_spacing", 32'(cyc - last_done), 32'd18);
        last_done = cyc;
        ndone++;
      end
    end
    chk("cont_count", 32'(ndone), 32'd3);
    START = 1'b0;
    tick(25);

    // Abort mid-RUN: no completion, product cleared.
    d0 = done_cnt;
    A = 16'h1111; B = 16'h2222; START = 1'b1;
    tick(1);
    START = 1'b0;
    tick(7);
    chk("abort_busy_before", 32'(BUSY), 32'd1);
    CLR = 1'b1;
    tick(1);
    CLR = 1'b0;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_p", P, 32'h0);
    tick(20);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_p_later", P, 32'h0);

    run_op(16'h0007, 16'h0009, 32'h0000_003F, 1'b0, "post_abort");
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/seq_mult_sixteen.md
# seq_mult_sixteen

Sequential 16×16 unsigned shift-and-add multiplier for the ALU library. It sits downstream of a pair of 16-bit operand registers and takes their gated `Qa` buses as `A` and `B`. It sits upstream of two 16-bit destination registers, driving their `D` inputs with the product halves and their `R_W` inputs with active-low write strobes. One multiply takes 16 iterations plus one completion cycle. A start/busy/done handshake sequences the multiplies.

## Interface
- `WIDTH`, default 16: operand width. The product is 2·`WIDTH` bits. Only 16 is verified.
- `CLK`  in  1: rising-edge clock, single clock domain.
- `CLR`  in  1: synchronous, active-high reset, sampled on the `CLK` rising edge.
- `START`  in  1: request a multiply. Accepted only in IDLE.
- `A`  in  16: multiplicand, sampled on the accepting edge.
- `B`  in  16: multiplier, sampled on the accepting edge.
- `BUSY`  out  1: high while in RUN.
- `DONE`  out  1: one-cycle completion pulse.
- `P`  out  32: registered product, held between completions.
- `OVF`  out  1: high when `P[31:16]` is nonzero, registered with `P`.
- `RW_LO`  out  1: active-low write strobe for the low-half destination register. It is 0 only while `DONE` is high, otherwise 1.
- `RW_HI`  out  1: active-low write strobe for the high-half destination register. Same timing as `RW_LO`.

## Operation
- **States:** IDLE, RUN, FIN. Encoding is implementer's choice. Illegal states return to IDLE on the next edge.
- **IDLE:** on an edge with `START`=1:
  - latch `A` into the multiplicand register `mcand`;
  - load the accumulator as {17'b0, `B`};
  - clear the 5-bit iteration counter `cnt`;
  - go to RUN.
  
  `START`=0 keeps the block in IDLE.
- **RUN, one iteration per edge:**
  - if `acc[0]`=1, then `acc[32:16]` ← `acc[31:16]` + `mcand`, using a 17-bit sum;
  - then shift the 33-bit `acc` right by 1;
  - `cnt` increments.
  
  When `cnt`=15 is processed, go to FIN.
- **Entering FIN:**
  - `P` ← `acc[31:0]` after the 16th iteration;
  - `OVF` ← |that value's `[31:16]`.
- **FIN:** `DONE`=1, `RW_LO`=0, `RW_HI`=0 for exactly one cycle. The next edge returns to IDLE.
- **Width rules:**
  - unsigned only; the result is exact and no bits are lost;
  - `OVF` flags only that the product does not fit in 16 bits, and it does not affect `P`.
- **`START` outside IDLE** (in RUN or FIN) is ignored. Changes on `A`/`B` after acceptance have no effect.
- **Back-to-back operation:** `START` held at 1 causes acceptance on the edge that leaves FIN→IDLE's following edge. So accepts occur every 18 cycles.

## Timing
- **Reset** (`CLR`=1 at an edge), with priority over everything:
  - state ← IDLE;
  - `P`=0, `OVF`=0, `BUSY`=0, `DONE`=0, `RW_LO`=1, `RW_HI`=1;
  - `acc`, `mcand` and `cnt` are cleared.
- **Reset mid-RUN or in FIN** aborts the operation:
  - no `DONE` is issued;
  - `P` reads 0 from the next cycle on.
- **Latency**, with acceptance at edge k:
  - `BUSY`=1 after edges k … k+15, in the cycles following them;
  - FIN is entered at edge k+16, so `P`, `OVF`, `DONE` and the strobes are valid in the cycle after edge k+16;
  - IDLE is re-entered at edge k+17;
  - the earliest next accept is at edge k+18.
- **Output registration:** all outputs are registered; there is no combinational path from inputs to outputs.
- **`P` stability:** `P` is stable while `DONE`=1, so the destination registers capture it on edge k+17.
- **Mutual exclusion:** `BUSY` and `DONE` are never high together.

## Test plan
- **Reset values:** hold `CLR`=1 for 2 cycles with `START`=1.
  - Required: `P`=0, `OVF`=0, `BUSY`=0, `DONE`=0, `RW_LO`=`RW_HI`=1, and no accept.
- **Small product:** `A`=0x0003, `B`=0x0005, `START` pulsed at edge k.
  - Required: `BUSY`=1 for 16 cycles.
  - Required in the cycle after edge k+16: `DONE`=1, `P`=0x0000000F, `OVF`=0, strobes=0.
  - Required at edge k+17: `DONE` returns to 0 and the strobes to 1.
- **Maximum operands:** `A`=0xFFFF, `B`=0xFFFF.
  - Required: `P`=0xFFFE0001 and `OVF`=1.
  - Then `A`=0x1234, `B`=0x0000. Required: `P`=0, `OVF`=0.
- **Ignored inputs:** `A`=0x00FF, `B`=0x0101 accepted. Then `A` changes to 0xAAAA and `B` to 0x5555 during RUN, and `START` pulses during RUN and during FIN.
  - Required: `P`=0x0000FFFF, exactly one `DONE`, and no extra operation.
- **Continuous start:** `START` held at 1, with `A`=0x0100 and `B`=0x0100 throughout.
  - Required: `DONE` pulses exactly 18 cycles apart, each with `P`=0x00010000 and `OVF`=1.
- **Abort:** `CLR`=1 for one edge, 8 cycles into RUN.
  - Required: `BUSY`=0 next cycle, no `DONE` appears, and `P`=0.
  - Then a fresh `A`=0x0007, `B`=0x0009. Required: `P`=0x0000003F after the nominal latency.
